// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TAG  = 3'd1,
        ST_DATA = 3'd2,
        ST_WAIT = 3'd3,
        ST_GAP  = 3'd4
    } tx_sched_state_t;

    typedef enum logic {
        PH_TAG  = 1'b0,
        PH_DATA = 1'b1
    } tx_phase_t;

    localparam logic [7:0] UART_ASCII_ZERO = 8'h30;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr+1
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler in front of one UART transmitter
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int         N_CH     = 4,
    parameter int         GAP      = 16,
    parameter bit         TAG_EN   = 1'b1,
    parameter logic [7:0] TAG_BASE = UART_ASCII_ZERO,
    localparam int        IW       = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req_valid,
    input  logic [8*N_CH-1:0] req_data,
    output logic [N_CH-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [IW-1:0]     grant_ch,
    output logic              active
);

    tx_sched_state_t state_q, state_d;
    tx_phase_t       phase_q, phase_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_ch_q, last_ch_d;
    logic            last_vld_q, last_vld_d;
    logic            guard_q, guard_d;
    logic [15:0]     gap_q, gap_d;
    logic [7:0]      data_q, data_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic [N_CH-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic [7:0]      req_byte;
    logic            need_tag;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign req_byte = req_data[{arb_idx, 3'b000} +: 8];
    assign need_tag = TAG_EN && (!last_vld_q || (last_ch_q != arb_idx));

    // tx_start/tx_data are registered alongside the state so they line up with TAG/DATA
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        last_ch_d  = last_ch_q;
        last_vld_d = last_vld_q;
        guard_d    = guard_q;
        gap_d      = gap_q;
        data_d     = data_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        req_ready  = '0;
        case (state_q)
            ST_IDLE: begin
                if ((|req_valid) && !rst) begin
                    req_ready  = arb_gnt;
                    grant_d    = arb_idx;
                    rr_ptr_d   = arb_idx;
                    data_d     = req_byte;
                    tx_start_d = 1'b1;
                    if (need_tag) begin
                        state_d   = ST_TAG;
                        tx_data_d = TAG_BASE + 8'(arb_idx);
                    end else begin
                        state_d   = ST_DATA;
                        tx_data_d = req_byte;
                    end
                end
            end
            ST_TAG: begin
                phase_d = PH_TAG;
                guard_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_DATA: begin
                phase_d    = PH_DATA;
                last_ch_d  = grant_q;
                last_vld_d = 1'b1;
                guard_d    = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // busy may rise one cycle after start, so the first WAIT cycle is blind
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!tx_busy) begin
                    if (phase_q == PH_TAG) begin
                        state_d    = ST_DATA;
                        tx_start_d = 1'b1;
                        tx_data_d  = data_q;
                    end else if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = 16'(GAP - 1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_TAG;
            rr_ptr_q   <= IW'(N_CH - 1);
            grant_q    <= '0;
            last_ch_q  <= '0;
            last_vld_q <= 1'b0;
            guard_q    <= 1'b0;
            gap_q      <= '0;
            data_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            last_ch_q  <= last_ch_d;
            last_vld_q <= last_vld_d;
            guard_q    <= guard_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_ch = grant_q;
    assign active   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int GAP_V  = 16;
    localparam int BUSY_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_data;
    logic        tx_start, tx_busy, active;
    logic [7:0]  tx_data;
    logic [1:0]  grant_ch;

    logic [3:0]  nt_valid = '0, nt_ready;
    logic [31:0] nt_data = '0;
    logic        nt_start, nt_busy, nt_active;
    logic [7:0]  nt_txd;
    logic [1:0]  nt_grant;

    uart_tx_sched #(.N_CH(4), .GAP(GAP_V), .TAG_EN(1'b1), .TAG_BASE(8'h30)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_ch(grant_ch), .active(active)
    );

    uart_tx_sched #(.N_CH(4), .GAP(0), .TAG_EN(1'b0), .TAG_BASE(8'h30)) dut_nt (
        .clk(clk), .rst(rst), .req_valid(nt_valid), .req_data(nt_data),
        .req_ready(nt_ready), .tx_start(nt_start), .tx_data(nt_txd),
        .tx_busy(nt_busy), .grant_ch(nt_grant), .active(nt_active)
    );

    // transmitter models: busy rises the cycle after tx_start, lasts a fixed length
    int bcnt, nt_bcnt;
    always @(posedge clk or posedge rst) begin
        if (rst)               bcnt <= 0;
        else if (tx_start)     bcnt <= BUSY_W;
        else if (bcnt != 0)    bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0);

    always @(posedge clk or posedge rst) begin
        if (rst)               nt_bcnt <= 0;
        else if (nt_start)     nt_bcnt <= 2;
        else if (nt_bcnt != 0) nt_bcnt <= nt_bcnt - 1;
    end
    assign nt_busy = (nt_bcnt != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] chb [4][4];
    int chcnt [4];
    int chbase [4];
    int chpop [4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (req_ready[i]) chpop[i] <= chpop[i] + 1;
    end

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = chpop[i] - chbase[i];
            if (k >= 0 && k < chcnt[i] && k < 4) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = chb[i][k];
            end
        end
    end

    int         st_cyc [$];
    logic [7:0] st_dat [$];
    int         fall_cyc [$];
    int         acc_cyc [$];
    logic [3:0] acc_oh [$];
    logic       busy_prev = 1'b0;
    int         viol = 0;
    int         nt_starts = 0;
    logic [7:0] nt_last = '0;

    always @(negedge clk) begin
        if (tx_start) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(tx_data);
            if (tx_busy) viol <= viol + 1;
        end
        if (busy_prev && !tx_busy) fall_cyc.push_back(cyc);
        busy_prev <= tx_busy;
        if (req_ready != '0) begin
            acc_cyc.push_back(cyc);
            acc_oh.push_back(req_ready);
        end
        if (nt_start) begin
            nt_starts <= nt_starts + 1;
            nt_last   <= nt_txd;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input int n, input logic [7:0] b0, input logic [7:0] b1);
        chbase[ch] = chpop[ch];
        chb[ch][0] = b0;
        chb[ch][1] = b1;
        chcnt[ch]  = n;
    endtask

    task automatic wait_done(input int s0, input int n, input string name);
        int k = 0;
        while (((st_dat.size() - s0) < n || active) && k < 2000) begin
            step();
            k++;
        end
        checks++;
        if (k >= 2000) begin
            errors++;
            $display("FAIL %s: timeout, starts seen %0d required %0d", name, st_dat.size() - s0, n);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) chcnt[i] = 0;
        rst = 1'b1;
        repeat (3) step();
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
        checks++; if (tx_start !== 1'b0)  begin errors++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        checks++; if (grant_ch !== 2'd0)  begin errors++; $display("FAIL rst_grant_ch: got %0d expected 0", grant_ch); end
        checks++; if (active !== 1'b0)    begin errors++; $display("FAIL rst_active: got %b expected 0", active); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int s0 = st_dat.size();
        int f0 = fall_cyc.size();
        int a0 = acc_cyc.size();
        load(2, 1, 8'h41, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        step();
        wait_done(s0, 2, "single_done");
        checks++; if (st_dat.size() - s0 != 2) begin errors++; $display("FAIL single_count: got %0d expected 2", st_dat.size() - s0); end
        checks++; if (st_dat[s0] !== 8'h32) begin errors++; $display("FAIL single_tag: got %h expected 32", st_dat[s0]); end
        checks++; if (st_dat[s0+1] !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", st_dat[s0+1]); end
        checks++; if (st_cyc[s0] != acc_cyc[a0] + 1) begin errors++; $display("FAIL single_start_lat: got %0d expected %0d", st_cyc[s0], acc_cyc[a0] + 1); end
        checks++; if (st_cyc[s0+1] != fall_cyc[f0] + 1) begin errors++; $display("FAIL single_payload_lat: got %0d expected %0d", st_cyc[s0+1], fall_cyc[f0] + 1); end
        checks++; if (grant_ch !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", grant_ch); end
    endtask

    task automatic test_same_channel();
        int s0 = st_dat.size();
        int f0 = fall_cyc.size();
        int a0 = acc_cyc.size();
        load(2, 2, 8'h41, 8'h42);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL same_ready: got %b expected 0100", req_ready); end
        wait_done(s0, 2, "same_done");
        checks++; if (st_dat.size() - s0 != 2) begin errors++; $display("FAIL same_count: got %0d expected 2", st_dat.size() - s0); end
        checks++; if (st_dat[s0] !== 8'h41) begin errors++; $display("FAIL same_first: got %h expected 41", st_dat[s0]); end
        checks++; if (st_dat[s0+1] !== 8'h42) begin errors++; $display("FAIL same_second: got %h expected 42", st_dat[s0+1]); end
        checks++; if (acc_cyc[a0+1] != fall_cyc[f0] + GAP_V + 1) begin errors++; $display("FAIL same_gap: got %0d expected %0d", acc_cyc[a0+1], fall_cyc[f0] + GAP_V + 1); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [10] = '{8'h30, 8'hA0, 8'h31, 8'hA1, 8'h32, 8'hA2, 8'h33, 8'hA3, 8'h30, 8'hA4};
        logic [3:0] exp_g [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int s0, a0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        s0 = st_dat.size();
        a0 = acc_oh.size();
        load(0, 2, 8'hA0, 8'hA4);
        load(1, 1, 8'hA1, 8'h00);
        load(2, 1, 8'hA2, 8'h00);
        load(3, 1, 8'hA3, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready: got %b expected 0001", req_ready); end
        wait_done(s0, 10, "rr_done");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (acc_oh[a0+i] !== exp_g[i]) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, acc_oh[a0+i], exp_g[i]); end
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (st_dat[s0+i] !== exp_d[i]) begin errors++; $display("FAIL rr_byte%0d: got %h expected %h", i, st_dat[s0+i], exp_d[i]); end
        end
    endtask

    task automatic test_busy_guard();
        int s0 = st_dat.size();
        int f0 = fall_cyc.size();
        load(1, 1, 8'h55, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL guard_ready: got %b expected 0010", req_ready); end
        step();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h31) begin errors++; $display("FAIL guard_tag_start: got %b/%h expected 1/31", tx_start, tx_data); end
        step();
        checks++; if (tx_start !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL guard_first_wait: got start %b busy %b expected 0 1", tx_start, tx_busy); end
        step();
        checks++; if (tx_start !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL guard_hold: got start %b active %b expected 0 1", tx_start, active); end
        wait_done(s0, 2, "guard_done");
        checks++; if (st_dat[s0+1] !== 8'h55) begin errors++; $display("FAIL guard_data: got %h expected 55", st_dat[s0+1]); end
        checks++; if (st_cyc[s0+1] != fall_cyc[f0] + 1) begin errors++; $display("FAIL guard_payload_lat: got %0d expected %0d", st_cyc[s0+1], fall_cyc[f0] + 1); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d [4] = '{8'h30, 8'h10, 8'h33, 8'h99};
        int s0;
        load(3, 1, 8'h77, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_ready: got %b expected 1000", req_ready); end
        step();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL mid_tag_start: got %b expected 1", tx_start); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (tx_start !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL mid_async: got start %b active %b expected 0 0", tx_start, active); end
        step();
        rst = 1'b0;
        s0 = st_dat.size();
        load(0, 1, 8'h10, 8'h00);
        load(3, 1, 8'h99, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_prio: got %b expected 0001", req_ready); end
        wait_done(s0, 4, "mid_done");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st_dat[s0+i] !== exp_d[i]) begin errors++; $display("FAIL mid_byte%0d: got %h expected %h", i, st_dat[s0+i], exp_d[i]); end
        end
    endtask

    task automatic test_tag_disabled();
        int n0 = nt_starts;
        int k = 0;
        nt_data  = 32'h0000_FF00;
        nt_valid = 4'b0010;
        #1;
        checks++; if (nt_ready !== 4'b0010) begin errors++; $display("FAIL notag_ready: got %b expected 0010", nt_ready); end
        step();
        nt_valid = 4'b0000;
        while (nt_active && k < 200) begin
            step();
            k++;
        end
        step();
        checks++; if (k >= 200) begin errors++; $display("FAIL notag_timeout: still active after %0d cycles", k); end
        checks++; if (nt_starts - n0 != 1) begin errors++; $display("FAIL notag_count: got %0d expected 1", nt_starts - n0); end
        checks++; if (nt_last !== 8'hFF) begin errors++; $display("FAIL notag_data: got %h expected FF", nt_last); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_channel();
        test_round_robin();
        test_busy_guard();
        test_reset_mid();
        test_tag_disabled();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL start_while_busy: got %0d expected 0", viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
